// File: rtl/gpio_pad_config.sv
// gpio_pad_config: serially configured control stage for one mprj_io pad.
// Daisy-chains through serial_data_out and commits full words into cfg.
module gpio_pad_config #(
  parameter int CONFIG_BITS = 10,
  parameter logic [CONFIG_BITS-1:0] RESET_CONFIG = 10'h007
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_data_in,
  input  logic       serial_shift,
  input  logic       serial_load,
  output logic       serial_data_out,
  output logic       load_err,
  input  logic       mgmt_gpio_out,
  input  logic       mgmt_gpio_oe,
  output logic       mgmt_gpio_in,
  input  logic       user_gpio_out,
  input  logic       user_gpio_oe,
  output logic       user_gpio_in,
  input  logic       pad_gpio_in,
  output logic       pad_gpio_out,
  output logic       pad_gpio_oe,
  output logic       pad_gpio_ie,
  output logic       pad_gpio_pu,
  output logic       pad_gpio_pd,
  output logic       pad_gpio_schmitt,
  output logic       pad_gpio_slew,
  output logic [1:0] pad_gpio_drive
);

  localparam logic [3:0] FULL = 4'(CONFIG_BITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state;

  logic [CONFIG_BITS-1:0] sr;
  logic [CONFIG_BITS-1:0] cfg;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic       err;
  logic       sync_q1;
  logic       sync_q2;

  logic       mgmt_en;
  logic       out_dis;
  logic       ie;
  logic       pu;
  logic       pd;
  logic       cs;
  logic       sl;
  logic [1:0] drive;
  logic       oe_force;
  logic       oe_src;

  assign mgmt_en  = cfg[0];
  assign out_dis  = cfg[1];
  assign ie       = cfg[2];
  assign pu       = cfg[3];
  assign pd       = cfg[4];
  assign cs       = cfg[5];
  assign sl       = cfg[6];
  assign drive    = cfg[8:7];
  assign oe_force = cfg[9];

  // Count including this cycle's shift, so a load on the last bit commits.
  assign cnt_inc = (serial_shift && cnt != FULL) ? cnt + 4'd1 : cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      cfg     <= RESET_CONFIG;
      cnt     <= '0;
      err     <= 1'b0;
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pad_gpio_in;
      sync_q2 <= sync_q1;
      if (serial_shift) begin
        sr <= {sr[CONFIG_BITS-2:0], serial_data_in};
      end
      unique case (state)
        COMMIT: begin
          cfg   <= sr;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt <= cnt_inc;
          if (serial_load) begin
            if (cnt_inc == FULL) begin
              state <= COMMIT;
            end else begin
              err   <= 1'b1;
              cnt   <= '0;
              state <= IDLE;
            end
          end else if (serial_shift) begin
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    pad_gpio_out = 1'b0;
    oe_src       = 1'b0;
    unique case (1'b1)
      mgmt_en: begin
        pad_gpio_out = mgmt_gpio_out;
        oe_src       = mgmt_gpio_oe;
      end
      default: begin
        pad_gpio_out = user_gpio_out;
        oe_src       = user_gpio_oe;
      end
    endcase
  end

  assign pad_gpio_oe      = ~out_dis & (oe_force | oe_src);
  assign pad_gpio_ie      = ie;
  assign pad_gpio_pu      = pu;
  // Pull-up wins when both pulls are requested.
  assign pad_gpio_pd      = pd & ~pu;
  assign pad_gpio_schmitt = cs;
  assign pad_gpio_slew    = sl;
  assign pad_gpio_drive   = drive;

  assign serial_data_out = sr[CONFIG_BITS-1];
  assign load_err        = err;
  assign mgmt_gpio_in    = sync_q2 & ie;
  assign user_gpio_in    = pad_gpio_in & ie;

endmodule
